// File: rtl/ram_responder.sv
// Byte-wide RAM responder with a memory-mapped UART TX buffer (data at 0x30000, status at 0x30004).
// Define TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise the TX buffer is a single holding register.
`ifndef XLEN
`define XLEN 32
`endif

module ram_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [`XLEN-1:0] mem_ram_addr,
  input  logic [7:0]       mem_ram_data,
  input  logic             mem_ram_wr,
  output logic [7:0]       ram_data,
  output logic             io_buffer_full,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready
);

`ifdef TX_FIFO_EN
  localparam int DEPTH      = FIFO_DEPTH;
  localparam int WARN_LEVEL = FIFO_DEPTH - 1;
`else
  // Single holding register: the almost-full warning degenerates to plain full.
  localparam int DEPTH      = 1;
  localparam int WARN_LEVEL = 1;
`endif
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  overflow;
  logic                  is_io;
  logic                  io_tx;
  logic                  io_status;
  logic                  ram_wr;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH-1:0] ram_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_io     = (mem_ram_addr[17:16] == 2'b11);
  assign io_tx     = (mem_ram_addr == `XLEN'('h30000));
  assign io_status = (mem_ram_addr == `XLEN'('h30004));
  assign ram_idx   = mem_ram_addr[ADDR_WIDTH-1:0];
  assign ram_wr    = rdy && mem_ram_wr && !is_io;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign tx_valid = !empty && rdy;
  assign tx_data  = fifo_mem[rd_ptr];

  // A push into a full buffer is still accepted when the head leaves at the same edge.
  assign pop    = tx_valid && tx_ready;
  assign push   = rdy && mem_ram_wr && io_tx;
  assign accept = push && (!full || pop);

  always_comb begin
    count_next = count;
    if (accept && !pop)
      count_next = count + 1'b1;
    else if (pop && !accept)
      count_next = count - 1'b1;
  end

  // Storage arrays are not reset; the rst term abandons a write caught by reset.
  always_ff @(posedge clk) begin
    if (rst && ram_wr)
      ram[ram_idx] <= mem_ram_data;
    if (rst && accept)
      fifo_mem[wr_ptr] <= mem_ram_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_data       <= 8'h00;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      io_buffer_full <= 1'b0;
    end else if (rdy) begin
      if (mem_ram_wr)
        ram_data <= 8'h00;
      else if (io_status)
        ram_data <= {5'b0, overflow, empty, full};
      else if (is_io)
        ram_data <= 8'h00;
      else
        ram_data <= ram[ram_idx];

      if (push && full && !pop)
        overflow <= 1'b1;
      else if (!mem_ram_wr && io_status)
        overflow <= 1'b0;

      if (accept)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);

      count          <= count_next;
      io_buffer_full <= (count_next >= CW'(WARN_LEVEL));
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder; expectations follow TX_FIFO_EN
// (8-entry FIFO when defined, single holding register otherwise).
`ifndef XLEN
`define XLEN 32
`endif

module tb_ram_responder;

`ifdef TX_FIFO_EN
  localparam int DEPTH = 8;
  localparam int WARN  = 7;
`else
  localparam int DEPTH = 1;
  localparam int WARN  = 1;
`endif

  logic             clk;
  logic             rst;
  logic             rdy;
  logic [`XLEN-1:0] mem_ram_addr;
  logic [7:0]       mem_ram_data;
  logic             mem_ram_wr;
  logic [7:0]       ram_data;
  logic             io_buffer_full;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;

  int tests = 0;
  int fails = 0;

  ram_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_ram_addr   (mem_ram_addr),
    .mem_ram_data   (mem_ram_data),
    .mem_ram_wr     (mem_ram_wr),
    .ram_data       (ram_data),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [`XLEN-1:0] a, input logic [7:0] d, input logic w);
    mem_ram_addr = a;
    mem_ram_data = d;
    mem_ram_wr   = w;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rdy = 1'b1;
    tx_ready = 1'b0;
    drive('0, 8'h00, 1'b0);
    #12;
    tests++; if (ram_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_ram_data: got %h expected 00", ram_data); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    tests++; if (io_buffer_full !== 1'b0) begin fails++; $display("[TB] FAIL reset_buffer_full: got %b expected 0", io_buffer_full); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ram_rw;
    drive('h00010, 8'hA5, 1'b1); tick();
    tests++; if (ram_data !== 8'h00) begin fails++; $display("[TB] FAIL write_returns_zero: got %h expected 00", ram_data); end
    drive('h1FFFF, 8'h77, 1'b1); tick();
    drive('h00010, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'hA5) begin fails++; $display("[TB] FAIL ram_read_10: got %h expected a5", ram_data); end
    drive('h1FFFF, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'h77) begin fails++; $display("[TB] FAIL ram_read_top: got %h expected 77", ram_data); end
    drive('h20010, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'hA5) begin fails++; $display("[TB] FAIL ram_alias_20010: got %h expected a5", ram_data); end
    drive('h30008, 8'h3C, 1'b1); tick();
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL io_other_write_ignored: got %b expected 0", tx_valid); end
    drive('h00010, 8'h00, 1'b0); tick();
    drive('h30008, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'h00) begin fails++; $display("[TB] FAIL io_other_read: got %h expected 00", ram_data); end
    drive('h00000, 8'h00, 1'b0);
  endtask

  task automatic test_tx_order;
    logic [7:0] seq [3];
    seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive('h30000, seq[i], 1'b1); tick();
      tests++; if (tx_valid !== 1'b1) begin fails++; $display("[TB] FAIL tx_order_valid[%0d]: got %b expected 1", i, tx_valid); end
      tests++; if (tx_data !== seq[i]) begin fails++; $display("[TB] FAIL tx_order_data[%0d]: got %h expected %h", i, tx_data, seq[i]); end
    end
    drive('h00000, 8'h00, 1'b0); tick();
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL tx_order_drained: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic exp_full;
    tx_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      drive('h30000, 8'(8'h60 + i), 1'b1); tick();
      exp_full = (i >= WARN);
      tests++; if (io_buffer_full !== exp_full) begin fails++; $display("[TB] FAIL buffer_full_after_push%0d: got %b expected %b", i, io_buffer_full, exp_full); end
    end
    tests++; if (tx_data !== 8'h61) begin fails++; $display("[TB] FAIL overflow_head: got %h expected 61", tx_data); end
    drive('h30004, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'h05) begin fails++; $display("[TB] FAIL status_overflow: got %h expected 05", ram_data); end
    tick();
    tests++; if (ram_data !== 8'h01) begin fails++; $display("[TB] FAIL status_cleared: got %h expected 01", ram_data); end
    drive('h00000, 8'h00, 1'b0);
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp;
    tx_ready = 1'b1;
    drive('h30000, 8'h55, 1'b1); tick();
    tests++; if (io_buffer_full !== 1'b1) begin fails++; $display("[TB] FAIL full_push_pop_warn: got %b expected 1", io_buffer_full); end
    tx_ready = 1'b0;
    drive('h30004, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'h01) begin fails++; $display("[TB] FAIL full_push_pop_status: got %h expected 01", ram_data); end
    drive('h00000, 8'h00, 1'b0);
    tx_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      exp = (k == DEPTH - 1) ? 8'h55 : 8'(8'h62 + k);
      tests++; if (tx_valid !== 1'b1 || tx_data !== exp) begin fails++; $display("[TB] FAIL drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, tx_valid, tx_data, exp); end
      tick();
    end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL drain_empty: got %b expected 0", tx_valid); end
    tests++; if (io_buffer_full !== 1'b0) begin fails++; $display("[TB] FAIL drain_warn_clear: got %b expected 0", io_buffer_full); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rdy_stall;
    drive('h00020, 8'h11, 1'b1); tick();
    drive('h00020, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'h11) begin fails++; $display("[TB] FAIL stall_preload: got %h expected 11", ram_data); end
    rdy = 1'b0;
    drive('h00020, 8'h99, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (ram_data !== 8'h11 || tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_hold[%0d]: got data=%h valid=%b expected data=11 valid=0", c, ram_data, tx_valid); end
    end
    drive('h30000, 8'h77, 1'b1); tick();
    drive('h00020, 8'h99, 1'b1);
    rdy = 1'b1;
    tick();
    tests++; if (ram_data !== 8'h00 || tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_release: got data=%h valid=%b expected data=00 valid=0", ram_data, tx_valid); end
    drive('h00020, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'h99) begin fails++; $display("[TB] FAIL stall_write_done: got %h expected 99", ram_data); end
    drive('h30000, 8'h5A, 1'b1); tick();
    drive('h00000, 8'h00, 1'b0);
    rdy = 1'b0;
    tx_ready = 1'b1;
    #1;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL valid_gated_by_rdy: got %b expected 0", tx_valid); end
    tick();
    rdy = 1'b1;
    #1;
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin fails++; $display("[TB] FAIL no_pop_while_stalled: got valid=%b data=%h expected valid=1 data=5a", tx_valid, tx_data); end
    tick();
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("[TB] FAIL pop_after_stall: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 4; i++) begin
      drive('h30000, 8'(8'hB0 + i), 1'b1); tick();
    end
    drive('h00010, 8'h00, 1'b0); tick();
    tests++; if (tx_valid !== 1'b1 || ram_data !== 8'hA5) begin fails++; $display("[TB] FAIL pre_reset: got valid=%b data=%h expected valid=1 data=a5", tx_valid, ram_data); end
    drive('h00010, 8'hEE, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    tests++; if (tx_valid !== 1'b0 || ram_data !== 8'h00 || io_buffer_full !== 1'b0) begin fails++; $display("[TB] FAIL async_reset: got valid=%b data=%h warn=%b expected 0/00/0", tx_valid, ram_data, io_buffer_full); end
    @(posedge clk);
    #3;
    rst = 1'b1;
    drive('h00010, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'hA5) begin fails++; $display("[TB] FAIL ram_kept_over_reset: got %h expected a5", ram_data); end
    drive('h30004, 8'h00, 1'b0); tick();
    tests++; if (ram_data !== 8'h02) begin fails++; $display("[TB] FAIL status_after_reset: got %h expected 02", ram_data); end
    drive('h00000, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_tx_order();
    test_overflow();
    test_full_push_pop();
    test_rdy_stall();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, SHALL set the number of RAM index bits (2^ADDR_WIDTH bytes).
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the TX FIFO depth; it SHALL be a power of two and at least 4.
REQ-003 clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 rdy  input  1: global enable; while it is low, all state SHALL hold.
REQ-006 mem_ram_addr  input  `XLEN: byte address from the memory controller.
REQ-007 mem_ram_data  input  8: write byte.
REQ-008 mem_ram_wr  input  1: 1 = write cycle, 0 = read cycle.
REQ-009 ram_data  output  8: registered read byte returned to the memory controller.
REQ-010 io_buffer_full  output  1: TX buffer almost-full warning to the CPU.
REQ-011 tx_valid  output  1; tx_data  output  8; tx_ready  input  1: TX byte stream to the UART.

Function
REQ-012 Address decode SHALL be: IO region when mem_ram_addr[17:16] == 2'b11; otherwise RAM, indexed by mem_ram_addr[ADDR_WIDTH-1:0].
REQ-013 A RAM read SHALL return RAM[addr] on ram_data exactly one cycle after the address is presented (registered output, 1-cycle latency).
REQ-014 A RAM write with mem_ram_wr=1 SHALL update RAM[addr] at that edge, and ram_data SHALL become 8'h00 on the next cycle.
REQ-015 A write to 0x30000 SHALL push mem_ram_data into the TX FIFO; if the FIFO is full and no pop occurs in the same cycle, the byte SHALL be dropped and the sticky overflow flag set.
REQ-016 A read of 0x30004 SHALL return the status byte {5'b0, overflow, empty, full} one cycle later and SHALL clear overflow at the same edge.
REQ-017 Reads of any other IO address SHALL return 8'h00; writes to them SHALL be ignored.
REQ-018 tx_valid SHALL equal (!empty && rdy); tx_data SHALL equal the FIFO head byte.
REQ-019 A pop SHALL occur at an edge where tx_valid && tx_ready are both high.
REQ-020 A simultaneous push and pop SHALL leave the count unchanged, including when the FIFO is full, and the push SHALL be accepted.
REQ-021 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL span 0..FIFO_DEPTH.
REQ-022 io_buffer_full SHALL be registered and SHALL be high when, after the current edge, count >= FIFO_DEPTH-1.

Reset
REQ-023 On rst low, ram_data, the FIFO pointers, the count, overflow and io_buffer_full SHALL be set to 0 immediately, regardless of clk.
REQ-024 RAM contents SHALL NOT be cleared by reset.
REQ-025 A transfer that is mid-operation when reset asserts SHALL be abandoned, with no RAM write and no push.
REQ-026 The first cycle after rst is released SHALL be treated as a normal cycle.

Configuration
REQ-027 With TX_FIFO_EN defined, the TX buffer SHALL be the FIFO_DEPTH-entry FIFO described above.
REQ-028 Without TX_FIFO_EN, the TX buffer SHALL be a single holding register with an effective depth of 1, and io_buffer_full SHALL equal full.
REQ-029 Without TX_FIFO_EN, overflow, status-read and simultaneous push/pop rules SHALL still apply, with depth 1.

Verification
REQ-030 Write 0xA5 to 0x00010, then read 0x00010 -> ram_data = 0xA5 exactly one cycle after the read address.
REQ-031 Write 0x41, 0x42, 0x43 to 0x30000 with tx_ready=1 -> tx_data shows 0x41, 0x42, 0x43 in order, then tx_valid=0.
REQ-032 With tx_ready=0, write 9 bytes to 0x30000 -> io_buffer_full rises after the 7th push, the 9th byte is dropped, and a read of 0x30004 returns 0x05; a second read of 0x30004 returns 0x01.
REQ-033 With the FIFO full, push 0x55 while tx_ready=1 -> the count stays at 8 and 0x55 is emitted last.
REQ-034 Drop rdy for 3 cycles during a write to 0x00020 -> RAM and FIFO are unchanged and tx_valid=0; the write completes once rdy returns high.
REQ-035 Assert rst low mid-stream with 4 bytes queued -> tx_valid=0 and ram_data=0 immediately, and RAM[0x10] still reads back 0xA5.
